// File: rtl/maskmul_sched.sv
// Round-robin scheduler that feeds one of two requesters into a masked-multiply datapath.
// Define MASKMUL_SCHED_LFSR_EN to build the mask LFSR; otherwise the output mask is 2'b00.
module maskmul_sched #(
    parameter int unsigned MUL_LAT   = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_am,
    input  logic [1:0]  req0_bm,
    input  logic [1:0]  req0_ma,
    input  logic [1:0]  req0_mb,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_am,
    input  logic [1:0]  req1_bm,
    input  logic [1:0]  req1_ma,
    input  logic [1:0]  req1_mb,
    output logic        mm_en,
    output logic [1:0]  mm_am,
    output logic [1:0]  mm_bm,
    output logic [1:0]  mm_ma,
    output logic [1:0]  mm_mb,
    output logic [1:0]  mm_mq,
    input  logic [1:0]  mm_qm,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [1:0]  rsp_qm,
    output logic [1:0]  rsp_mq,
    input  logic        rsp_ready,
    output logic [1:0]  dbg_state,
    output logic        dbg_ptr,
    output logic [15:0] dbg_lfsr
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_ISSUE = 2'd1;
    localparam logic [1:0]  ST_RESP  = 2'd2;
    localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [3:0]  LAT      = 4'(MUL_LAT);

    logic [1:0] state_q, state_d;
    logic       ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic       id_q, id_d;
    logic [7:0] ops_q, ops_d;
    logic [1:0] mq_q, mq_d;
    logic [1:0] qm_q, qm_d;
    logic       any_valid;
    logic       grant;
    logic       accept;
    logic [1:0] mq_next;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // Requester ready is a combinational grant in IDLE only; rsp_valid holds its payload
    // stable until rsp_ready is seen high at an edge.
    assign any_valid  = req0_valid | req1_valid;
    assign grant      = (ptr_q ? req1_valid : req0_valid) ? ptr_q : ~ptr_q;
    assign accept     = (state_q == ST_IDLE) && any_valid && rst_n;
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;

`ifdef MASKMUL_SCHED_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, stepped only when a request is taken.
    always_comb begin
        lfsr_d = lfsr_q;
        if (accept) begin
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign mq_next  = lfsr_q[1:0];
    assign dbg_lfsr = lfsr_q;
`else
    assign mq_next  = 2'b00;
    assign dbg_lfsr = 16'h0000;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        ops_d   = ops_q;
        mq_d    = mq_q;
        qm_d    = qm_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ISSUE;
                    id_d    = grant;
                    mq_d    = mq_next;
                    cnt_d   = LAT;
                    ops_d   = grant ? {req1_am, req1_bm, req1_ma, req1_mb}
                                    : {req0_am, req0_bm, req0_ma, req0_mb};
                end
            end
            ST_ISSUE: begin
                cnt_d = cnt_q - 4'd1;
                // The datapath result is valid during the last issue cycle.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    qm_d    = mm_qm;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    ptr_d   = ~id_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= 4'd0;
            id_q    <= 1'b0;
            ops_q   <= 8'h00;
            mq_q    <= 2'b00;
            qm_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            ops_q   <= ops_d;
            mq_q    <= mq_d;
            qm_q    <= qm_d;
        end
    end

    assign mm_en                        = (state_q == ST_ISSUE);
    assign {mm_am, mm_bm, mm_ma, mm_mb} = mm_en ? ops_q : 8'h00;
    assign mm_mq                        = mm_en ? mq_q : 2'b00;
    assign rsp_valid                    = (state_q == ST_RESP);
    assign rsp_id                       = id_q;
    assign rsp_qm                       = qm_q;
    assign rsp_mq                       = mq_q;
    assign dbg_state                    = state_q;
    assign dbg_ptr                      = ptr_q;

endmodule

// File: tb/tb_maskmul_sched.sv
// Bench for maskmul_sched: three instances (MUL_LAT 1, 4, 3) driven one at a time,
// with the bench acting as the maskmul datapath and scoring results through a queue.
module tb_maskmul_sched;

    localparam int N = 3;

    logic        clk;
    logic        rst_n      [N];
    logic        req0_valid [N];
    logic        req1_valid [N];
    logic        req0_ready [N];
    logic        req1_ready [N];
    logic [1:0]  req0_am [N], req0_bm [N], req0_ma [N], req0_mb [N];
    logic [1:0]  req1_am [N], req1_bm [N], req1_ma [N], req1_mb [N];
    logic        mm_en [N];
    logic [1:0]  mm_am [N], mm_bm [N], mm_ma [N], mm_mb [N], mm_mq [N], mm_qm [N];
    logic        rsp_valid [N], rsp_id [N], rsp_ready [N];
    logic [1:0]  rsp_qm [N], rsp_mq [N];
    logic [1:0]  dbg_state [N];
    logic        dbg_ptr [N];
    logic [15:0] dbg_lfsr [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        maskmul_sched #(
            .MUL_LAT   ((g == 0) ? 1 : ((g == 1) ? 4 : 3)),
            .LFSR_SEED (16'hACE1)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n[g]),
            .req0_valid (req0_valid[g]),
            .req0_ready (req0_ready[g]),
            .req0_am    (req0_am[g]),
            .req0_bm    (req0_bm[g]),
            .req0_ma    (req0_ma[g]),
            .req0_mb    (req0_mb[g]),
            .req1_valid (req1_valid[g]),
            .req1_ready (req1_ready[g]),
            .req1_am    (req1_am[g]),
            .req1_bm    (req1_bm[g]),
            .req1_ma    (req1_ma[g]),
            .req1_mb    (req1_mb[g]),
            .mm_en      (mm_en[g]),
            .mm_am      (mm_am[g]),
            .mm_bm      (mm_bm[g]),
            .mm_ma      (mm_ma[g]),
            .mm_mb      (mm_mb[g]),
            .mm_mq      (mm_mq[g]),
            .mm_qm      (mm_qm[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_id     (rsp_id[g]),
            .rsp_qm     (rsp_qm[g]),
            .rsp_mq     (rsp_mq[g]),
            .rsp_ready  (rsp_ready[g]),
            .dbg_state  (dbg_state[g]),
            .dbg_ptr    (dbg_ptr[g]),
            .dbg_lfsr   (dbg_lfsr[g])
        );
    end

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard entry: {id, mq, am, bm, ma, mb}
    logic [10:0] exp_q [$];
    logic        grant_log [$];
    int          n_vec;
    int          n_err;
    int          cyc;
    int          acc_cyc [N];
    int          issue_n [N];
    logic [15:0] lfsr_m  [N];
    logic        ptr_m   [N];
    logic        prev_rv [N];
    logic        acc_seen [N];
    logic        hs_seen  [N];
    logic [1:0]  last_qm [N];
    logic [4:0]  exp_rsp [N];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 4 : 3);
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic logic [1:0] mq_of(input logic [15:0] l);
`ifdef MASKMUL_SCHED_LFSR_EN
        return l[1:0];
`else
        return 2'b00;
`endif
    endfunction

    function automatic logic [15:0] lfsr_reset_view();
`ifdef MASKMUL_SCHED_LFSR_EN
        return 16'hACE1;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic        acc0, acc1, gid, eg;
        logic [10:0] e;
        for (int i = 0; i < N; i++) begin
            acc_seen[i] = 1'b0;
            hs_seen[i]  = 1'b0;
            if (rst_n[i]) begin
                acc0 = req0_valid[i] && req0_ready[i];
                acc1 = req1_valid[i] && req1_ready[i];
                if (acc0 || acc1) begin
                    chk("single_grant", {31'b0, acc0 && acc1}, 32'd0);
                    eg  = (ptr_m[i] ? req1_valid[i] : req0_valid[i]) ? ptr_m[i] : !ptr_m[i];
                    gid = acc1;
                    chk("grant_id", {31'b0, gid}, {31'b0, eg});
                    if (gid) e = {1'b1, mq_of(lfsr_m[i]), req1_am[i], req1_bm[i], req1_ma[i], req1_mb[i]};
                    else     e = {1'b0, mq_of(lfsr_m[i]), req0_am[i], req0_bm[i], req0_ma[i], req0_mb[i]};
                    exp_q.push_back(e);
                    grant_log.push_back(gid);
                    lfsr_m[i]   = lfsr_step(lfsr_m[i]);
                    acc_cyc[i]  = cyc;
                    issue_n[i]  = 0;
                    acc_seen[i] = 1'b1;
                end
                if (mm_en[i]) begin
                    issue_n[i]++;
                    last_qm[i] = mm_qm[i];
                    if (exp_q.size() > 0) begin
                        e = exp_q[0];
                        chk("mm_bus", {22'b0, mm_am[i], mm_bm[i], mm_ma[i], mm_mb[i], mm_mq[i]},
                            {22'b0, e[7:0], e[9:8]});
                    end else begin
                        chk("mm_orphan", 32'(exp_q.size()), 32'd1);
                    end
                end else begin
                    chk("mm_idle_zero", {22'b0, mm_am[i], mm_bm[i], mm_ma[i], mm_mb[i], mm_mq[i]}, 32'd0);
                end
                if (rsp_valid[i] && !prev_rv[i]) begin
                    chk("latency", 32'(cyc - acc_cyc[i]), 32'(lat_of(i) + 1));
                    chk("issue_len", 32'(issue_n[i]), 32'(lat_of(i)));
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        exp_rsp[i] = {e[10], e[9:8], last_qm[i]};
                        chk("rsp_fields", {27'b0, rsp_id[i], rsp_mq[i], rsp_qm[i]}, {27'b0, exp_rsp[i]});
                    end else begin
                        chk("rsp_orphan", 32'(exp_q.size()), 32'd1);
                    end
                end
                if (rsp_valid[i] && rsp_ready[i]) begin
                    ptr_m[i]   = !exp_rsp[i][4];
                    hs_seen[i] = 1'b1;
                end
                prev_rv[i] = rsp_valid[i];
            end else begin
                prev_rv[i] = 1'b0;
                ptr_m[i]   = 1'b0;
                lfsr_m[i]  = 16'hACE1;
                issue_n[i] = 0;
            end
        end
    endtask

    // One clock: sample at the falling edge, then update inputs just after the rising edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        monitor();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) mm_qm[i] = 2'($urandom_range(0, 3));
    endtask

    task automatic set_ops(input int i, input bit which, input logic [7:0] ops);
        if (which) {req1_am[i], req1_bm[i], req1_ma[i], req1_mb[i]} = ops;
        else       {req0_am[i], req0_bm[i], req0_ma[i], req0_mb[i]} = ops;
    endtask

    task automatic send(input int i, input bit which, input logic [7:0] ops, input int budget);
        logic done;
        done = 1'b0;
        set_ops(i, which, ops);
        if (which) req1_valid[i] = 1'b1;
        else       req0_valid[i] = 1'b1;
        for (int k = 0; k < budget && !done; k++) begin
            step();
            done = acc_seen[i];
        end
        chk("accepted", {31'b0, done}, 32'd1);
        req0_valid[i] = 1'b0;
        req1_valid[i] = 1'b0;
    endtask

    task automatic wait_hs(input int i, input int budget);
        logic done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            step();
            done = hs_seen[i];
        end
        chk("rsp_handshake", {31'b0, done}, 32'd1);
    endtask

    initial begin
        int   hs_cnt;
        logic got;
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        for (int i = 0; i < N; i++) begin
            rst_n[i] = 1'b0;
            req0_valid[i] = 1'b0;
            req1_valid[i] = 1'b0;
            set_ops(i, 1'b0, 8'h00);
            set_ops(i, 1'b1, 8'h00);
            rsp_ready[i] = 1'b0;
            mm_qm[i]     = 2'b00;
            acc_cyc[i]   = 0;
            issue_n[i]   = 0;
            lfsr_m[i]    = 16'hACE1;
            ptr_m[i]     = 1'b0;
            prev_rv[i]   = 1'b0;
            acc_seen[i]  = 1'b0;
            hs_seen[i]   = 1'b0;
            last_qm[i]   = 2'b00;
            exp_rsp[i]   = 5'd0;
        end

        // Reset state, with a request pending to show ready is held low
        req0_valid[0] = 1'b1;
        #3;
        chk("rst_ready0", {31'b0, req0_ready[0]}, 32'd0);
        chk("rst_mm_en", {31'b0, mm_en[0]}, 32'd0);
        chk("rst_rsp", {27'b0, rsp_valid[0], rsp_id[0], rsp_qm[0]}, 32'd0);
        chk("rst_state", {30'b0, dbg_state[0]}, 32'd0);
        chk("rst_ptr", {31'b0, dbg_ptr[0]}, 32'd0);
        chk("rst_lfsr", {16'b0, dbg_lfsr[0]}, {16'b0, lfsr_reset_view()});
        step();
        step();
        req0_valid[0] = 1'b0;
        for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
        step();

        // Single request, MUL_LAT=1
        rsp_ready[0] = 1'b1;
        send(0, 1'b0, 8'b10_01_11_00, 10);
        wait_hs(0, 10);
        chk("idle_after_single", {30'b0, dbg_state[0]}, 32'd0);

        // Contention with MUL_LAT=4: both requesters valid throughout
        grant_log.delete();
        rsp_ready[1] = 1'b1;
        set_ops(1, 1'b0, 8'($urandom_range(0, 255)));
        set_ops(1, 1'b1, 8'($urandom_range(0, 255)));
        req0_valid[1] = 1'b1;
        req1_valid[1] = 1'b1;
        hs_cnt = 0;
        for (int k = 0; k < 100 && hs_cnt < 4; k++) begin
            step();
            if (hs_seen[1]) hs_cnt++;
        end
        req0_valid[1] = 1'b0;
        req1_valid[1] = 1'b0;
        chk("contention_rsps", 32'(hs_cnt), 32'd4);
        chk("contention_grants", 32'(grant_log.size()), 32'd4);
        for (int k = 0; k < 4 && k < grant_log.size(); k++) begin
            chk("alternate_grant", {31'b0, grant_log[k]}, 32'(k % 2));
        end

        // Backpressure: five stalled cycles in RESP with both requesters pushing
        rsp_ready[0] = 1'b0;
        send(0, 1'b1, 8'($urandom_range(0, 255)), 10);
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            step();
            got = rsp_valid[0];
        end
        chk("bp_reached_resp", {31'b0, got}, 32'd1);
        req0_valid[0] = 1'b1;
        req1_valid[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_valid", {31'b0, rsp_valid[0]}, 32'd1);
            chk("bp_payload", {27'b0, rsp_id[0], rsp_mq[0], rsp_qm[0]}, {27'b0, exp_rsp[0]});
            chk("bp_ready", {30'b0, req0_ready[0], req1_ready[0]}, 32'd0);
        end
        req0_valid[0] = 1'b0;
        req1_valid[0] = 1'b0;
        rsp_ready[0]  = 1'b1;
        step();
        chk("bp_release_idle", {30'b0, dbg_state[0]}, 32'd0);

        // Reset in the second issue cycle, MUL_LAT=3
        rsp_ready[2] = 1'b1;
        send(2, 1'b0, 8'($urandom_range(0, 255)), 10);
        wait_hs(2, 10);
        send(2, 1'b1, 8'($urandom_range(0, 255)), 10);
        step();
        chk("pre_rst_issue", {31'b0, mm_en[2]}, 32'd1);
        req0_valid[2] = 1'b1;
        rst_n[2] = 1'b0;
        #1;
        exp_q.delete();
        chk("midrst_mm_en", {31'b0, mm_en[2]}, 32'd0);
        chk("midrst_mm_bus", {22'b0, mm_am[2], mm_bm[2], mm_ma[2], mm_mb[2], mm_mq[2]}, 32'd0);
        chk("midrst_rsp", {26'b0, rsp_valid[2], rsp_id[2], rsp_mq[2], rsp_qm[2]}, 32'd0);
        chk("midrst_ready", {30'b0, req0_ready[2], req1_ready[2]}, 32'd0);
        step();
        step();
        req0_valid[2] = 1'b0;
        rst_n[2] = 1'b1;
        step();
        chk("post_rst_state", {30'b0, dbg_state[2]}, 32'd0);
        chk("post_rst_ptr", {31'b0, dbg_ptr[2]}, 32'd0);
        chk("post_rst_lfsr", {16'b0, dbg_lfsr[2]}, {16'b0, lfsr_reset_view()});
        for (int k = 0; k < 6; k++) step();
        chk("no_stale_rsp", {31'b0, rsp_valid[2]}, 32'd0);

        // Mask sequence over three accepts after reset
        for (int k = 0; k < 3; k++) begin
            send(2, k[0], 8'($urandom_range(0, 255)), 10);
            wait_hs(2, 10);
        end

        step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/maskmul_sched.md
MASKMUL_SCHED -- requirements
Module: maskmul_sched

Interface
REQ-001 Parameter MUL_LAT, default 1, meaning maskmul datapath latency in cycles; legal range 1..15.
REQ-002 Parameter LFSR_SEED, default 16'hACE1, meaning mask LFSR reset value; a value of 0 SHALL be replaced by 16'h0001.
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req0_valid / req1_valid  in  1 each  requester operand pair valid.
REQ-006 req0_ready / req1_ready  out  1 each  requester operand accepted this cycle.
REQ-007 reqN_am, reqN_bm, reqN_ma, reqN_mb  in  2 each (N=0,1)  masked operands and their input masks.
REQ-008 mm_en  out  1  high while the datapath is being driven.
REQ-009 mm_am, mm_bm, mm_ma, mm_mb, mm_mq  out  2 each  operands and masks driven to the maskmul datapath.
REQ-010 mm_qm  in  2  masked product returned by the datapath.
REQ-011 rsp_valid  out  1  result available.
REQ-012 rsp_id  out  1  index of the requester that owns the result.
REQ-013 rsp_qm, rsp_mq  out  2 each  masked result and its output mask.
REQ-014 rsp_ready  in  1  consumer accepts the result.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ISSUE and RESP.
REQ-016 IDLE: if any reqN_valid is high, reqN_ready SHALL be driven combinationally for exactly one granted requester. The grant SHALL go to the requester at the round-robin pointer if it is valid, otherwise to the other requester.
REQ-017 In IDLE with no valid request, both reqN_ready SHALL be 0 and the state SHALL remain IDLE.
REQ-018 On the accept edge, the block SHALL register the operands, register mq from LFSR[1:0], register the grant index, load the counter with MUL_LAT, and move to ISSUE.
REQ-019 ISSUE: mm_en SHALL be 1, mm_* SHALL hold the registered values, and the counter SHALL decrement each cycle.
REQ-020 On the closing edge of the ISSUE cycle in which the counter equals 1, mm_qm SHALL be captured into rsp_qm and the state SHALL move to RESP.
REQ-021 Latency: rsp_valid SHALL rise exactly MUL_LAT+1 cycles after the accept edge.
REQ-022 RESP: rsp_valid SHALL be 1 and rsp_id, rsp_qm and rsp_mq SHALL be stable until rsp_valid and rsp_ready are both high at an edge.
REQ-023 On that edge the state SHALL return to IDLE and the pointer SHALL be set to the other requester (not rsp_id).
REQ-024 In ISSUE and RESP, both reqN_ready SHALL be 0; no second request SHALL be accepted while one is in flight.
REQ-025 Outside ISSUE, mm_en SHALL be 0 and mm_* SHALL be 2'b00.
REQ-026 The LFSR SHALL be a 16-bit Fibonacci LFSR with polynomial x^16+x^14+x^13+x^11+1. It SHALL advance exactly one step per accepted request and never otherwise.
REQ-027 A requester that deasserts valid before it is granted SHALL lose its turn with no side effects.

Reset
REQ-028 While reset is low, the block SHALL asynchronously force: state=IDLE, pointer=0, counter=0, LFSR=LFSR_SEED (after the zero substitution), all outputs 0.
REQ-029 Reset asserted in ISSUE or RESP SHALL discard the in-flight operation with no response.
REQ-030 Deassertion SHALL take effect at the first rising clock edge after reset goes high.

Configuration
REQ-031 Macro MASKMUL_SCHED_LFSR_EN, when defined, SHALL enable the LFSR and mq generation exactly as in REQ-018 and REQ-026.
REQ-032 When MASKMUL_SCHED_LFSR_EN is undefined, the LFSR SHALL be absent, and mm_mq and rsp_mq SHALL be constant 2'b00 (unmasked debug build). All other behaviour SHALL be unchanged.

Verification
REQ-033 Single request: MUL_LAT=1, req0_valid=1 with am=2'b10, bm=2'b01, ma=2'b11, mb=2'b00, rsp_ready=1 -> req0_ready=1 in cycle 0, mm_en=1 in cycle 1, rsp_valid=1 and rsp_id=0 in cycle 2, rsp_qm equal to mm_qm sampled in cycle 1.
REQ-034 Contention: both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 across 4 transactions, and no requester is granted twice in a row.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_* remain stable, both reqN_ready=0; rsp_ready=1 -> return to IDLE on the next edge.
REQ-036 Latency sweep: MUL_LAT=4 -> mm_en high for exactly 4 cycles and rsp_valid rising 5 cycles after the accept edge.
REQ-037 Reset mid-operation: assert reset in the second ISSUE cycle (MUL_LAT=3) -> all outputs 0 immediately, and after release the state is IDLE, the pointer is 0 and the LFSR equals 16'hACE1.
REQ-038 LFSR: with the macro defined, 3 accepts after reset -> rsp_mq sequence matches the software LFSR model from 16'hACE1; with the macro undefined -> rsp_mq=2'b00 every time.
